// File: rtl/seven_segment_scheduler.sv
// seven_segment_scheduler
//   Time-shares one seven-segment display between NUM_SRC requesters. Each
//   source owns a one-frame slot (digits, points, loaded flag). Loaded slots
//   are shown in round-robin order for DWELL_CYCLES clocks each. A new frame
//   written to the source on display is pushed out immediately. Every frame
//   change is announced with a one-cycle seven_segment_tvalid strobe.
//
// Ports
//   clk                   rising-edge clock
//   rst_n                 asynchronous active-low reset
//   s_tvalid/s_tready     per-source frame handshake (ready is high out of reset)
//   s_tdata               source i digits at [i*NUM_SEGMENTS*4 +: NUM_SEGMENTS*4]
//   s_tuser               source i points at [i*NUM_SEGMENTS +: NUM_SEGMENTS]
//   src_clear             per-source request to drop its slot
//   hold                  freeze rotation on the current source
//   seven_segment_tvalid  frame-update strobe
//   seven_segment_tdata   displayed digits
//   seven_segment_tuser   displayed points
//   active_src            index of the source on display
module seven_segment_scheduler #(
  parameter int NUM_SEGMENTS = 8,
  parameter int NUM_SRC      = 4,
  parameter int DWELL_CYCLES = 50000000
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_SRC-1:0]                s_tvalid,
  output logic [NUM_SRC-1:0]                s_tready,
  input  logic [NUM_SRC*NUM_SEGMENTS*4-1:0] s_tdata,
  input  logic [NUM_SRC*NUM_SEGMENTS-1:0]   s_tuser,
  input  logic [NUM_SRC-1:0]                src_clear,
  input  logic                              hold,
  output logic                              seven_segment_tvalid,
  output logic [NUM_SEGMENTS*4-1:0]         seven_segment_tdata,
  output logic [NUM_SEGMENTS-1:0]           seven_segment_tuser,
  output logic [$clog2(NUM_SRC)-1:0]        active_src
);

  localparam int FRAME_W = NUM_SEGMENTS * 4;
  localparam int SRC_W   = $clog2(NUM_SRC);
  localparam int CNT_W   = $clog2(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHOW, NEXT} state_t;

  state_t                               state_q, state_d;
  logic [NUM_SRC-1:0]                   loaded_q, loaded_d;
  logic [NUM_SRC-1:0][FRAME_W-1:0]      data_q;
  logic [NUM_SRC-1:0][NUM_SEGMENTS-1:0] user_q;
  logic [CNT_W-1:0]                     cnt_q, cnt_d;
  logic [SRC_W-1:0]                     act_q, act_d;
  logic                                 tvalid_q, tvalid_d;
  logic [FRAME_W-1:0]                   tdata_q, tdata_d;
  logic [NUM_SEGMENTS-1:0]              tuser_q, tuser_d;
  logic                                 upd_q, upd_d;
  logic [NUM_SRC-1:0]                   wr;
  logic                                 low_hit, rr_hit;
  logic [SRC_W-1:0]                     low_idx, rr_idx;

  assign s_tready = {NUM_SRC{rst_n}};
  assign wr       = s_tvalid & s_tready;

  // A write beats a simultaneous clear on the same slot.
  assign loaded_d = (loaded_q & ~src_clear) | wr;

  // Slot frame storage; only ever read while its loaded flag is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (wr[i]) begin
        data_q[i] <= s_tdata[i*FRAME_W +: FRAME_W];
        user_q[i] <= s_tuser[i*NUM_SEGMENTS +: NUM_SEGMENTS];
      end
    end
  end

  function automatic logic [SRC_W-1:0] rr_pos(input logic [SRC_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_SRC) s = s - NUM_SRC;
    return SRC_W'(s);
  endfunction

  // Lowest-index loaded slot, used when leaving IDLE.
  always_comb begin
    low_hit = |loaded_q;
    low_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (loaded_q[i]) low_idx = SRC_W'(i);
    end
  end

  // Round-robin search from act_q+1, wrapping back to act_q itself. Scanning
  // offsets downward lets the nearest hit overwrite any farther one.
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = act_q;
    for (int off = NUM_SRC; off >= 1; off--) begin
      if (loaded_q[rr_pos(act_q, off)]) begin
        rr_hit = 1'b1;
        rr_idx = rr_pos(act_q, off);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    act_d    = act_q;
    tvalid_d = 1'b0;
    tdata_d  = tdata_q;
    tuser_d  = tuser_q;
    case (state_q)
      IDLE: begin
        if (low_hit) begin
          state_d  = SHOW;
          act_d    = low_idx;
          cnt_d    = '0;
          tvalid_d = 1'b1;
          tdata_d  = data_q[low_idx];
          tuser_d  = user_q[low_idx];
        end
      end
      SHOW: begin
        // A dropped slot or an expired dwell both move on; either one
        // outranks a pending live update.
        if (!loaded_q[act_q]) begin
          state_d = NEXT;
        end else if ((cnt_q == CNT_MAX) && !hold) begin
          state_d = NEXT;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
          if (upd_q) begin
            tvalid_d = 1'b1;
            tdata_d  = data_q[act_q];
            tuser_d  = user_q[act_q];
          end
        end
      end
      NEXT: begin
        if (rr_hit) begin
          state_d  = SHOW;
          act_d    = rr_idx;
          cnt_d    = '0;
          tvalid_d = 1'b1;
          tdata_d  = data_q[rr_idx];
          tuser_d  = user_q[rr_idx];
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Live update is armed only by a write that lands while the same source
    // stays on display; a frame written as it is being rotated away waits
    // in its slot for the next turn.
    upd_d = (state_q == SHOW) && (state_d == SHOW) && wr[act_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      loaded_q <= '0;
      cnt_q    <= '0;
      act_q    <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tuser_q  <= '0;
      upd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      loaded_q <= loaded_d;
      cnt_q    <= cnt_d;
      act_q    <= act_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tuser_q  <= tuser_d;
      upd_q    <= upd_d;
    end
  end

  assign seven_segment_tvalid = tvalid_q;
  assign seven_segment_tdata  = tdata_q;
  assign seven_segment_tuser  = tuser_q;
  assign active_src           = act_q;

endmodule

// File: tb/tb_seven_segment_scheduler.sv
module tb_seven_segment_scheduler;

  localparam int NS = 4;
  localparam int NSEG = 8;
  localparam int D = 8;
  localparam int P_IDLE = 0, P_SHOW = 1, P_SEARCH = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NS-1:0]   s_tvalid, s_tready, src_clear;
  logic [NS*32-1:0] s_tdata;
  logic [NS*8-1:0] s_tuser;
  logic            hold;
  logic            tv;
  logic [31:0]     td;
  logic [7:0]      tu;
  logic [1:0]      act;

  int checks = 0;
  int errors = 0;

  seven_segment_scheduler #(.NUM_SEGMENTS(NSEG), .NUM_SRC(NS), .DWELL_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tuser(s_tuser),
    .src_clear(src_clear), .hold(hold),
    .seven_segment_tvalid(tv), .seven_segment_tdata(td), .seven_segment_tuser(tu),
    .active_src(act)
  );

  always #5 clk = ~clk;

  // Behavioural reference: slots, what is on display, how long it has been up.
  bit          m_loaded[NS];
  logic [31:0] m_data[NS];
  logic [7:0]  m_user[NS];
  int          m_phase, m_act, m_age;
  bit          m_pend;
  bit          e_tv;
  logic [31:0] e_td;
  logic [7:0]  e_tu;

  task automatic model_reset();
    for (int i = 0; i < NS; i++) m_loaded[i] = 0;
    m_phase = P_IDLE; m_act = 0; m_age = 0; m_pend = 0;
    e_tv = 0; e_td = '0; e_tu = '0;
  endtask

  task automatic model_show(input int j);
    m_act = j; m_age = 0;
    e_tv = 1; e_td = m_data[j]; e_tu = m_user[j];
  endtask

  task automatic model_step();
    int nphase;
    int j;
    bit npend;
    nphase = m_phase; npend = 0; e_tv = 0; j = -1;
    if (m_phase == P_IDLE) begin
      for (int i = 0; i < NS; i++) if (j < 0 && m_loaded[i]) j = i;
      if (j >= 0) begin nphase = P_SHOW; model_show(j); end
    end else if (m_phase == P_SHOW) begin
      if (!m_loaded[m_act]) nphase = P_SEARCH;
      else if ((m_age % D) == D - 1 && !hold) nphase = P_SEARCH;
      else begin
        m_age++;
        if (m_pend) begin e_tv = 1; e_td = m_data[m_act]; e_tu = m_user[m_act]; end
      end
    end else begin
      for (int off = 1; off <= NS; off++)
        if (j < 0 && m_loaded[(m_act + off) % NS]) j = (m_act + off) % NS;
      if (j >= 0) begin nphase = P_SHOW; model_show(j); end
      else nphase = P_IDLE;
    end
    if (m_phase == P_SHOW && nphase == P_SHOW && s_tvalid[m_act]) npend = 1;
    for (int i = 0; i < NS; i++) begin
      if (s_tvalid[i]) begin
        m_loaded[i] = 1; m_data[i] = s_tdata[i*32 +: 32]; m_user[i] = s_tuser[i*8 +: 8];
      end else if (src_clear[i]) m_loaded[i] = 0;
    end
    m_phase = nphase; m_pend = npend;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("cmp_tvalid", 32'(tv), 32'(e_tv));
    check("cmp_tdata", td, e_td);
    check("cmp_tuser", 32'(tu), 32'(e_tu));
    check("cmp_active", 32'(act), 32'(m_act));
    check("cmp_tready", 32'(s_tready), 32'({NS{rst_n}}));
  end

  task automatic clear_inputs();
    s_tvalid = '0; src_clear = '0; hold = 1'b0; s_tdata = '0; s_tuser = '0;
  endtask

  task automatic set_src(input int i, input logic [31:0] d, input logic [7:0] u);
    s_tvalid[i] = 1'b1; s_tdata[i*32 +: 32] = d; s_tuser[i*8 +: 8] = u;
  endtask

  task automatic do_reset();
    @(negedge clk); #2 rst_n = 1'b0; clear_inputs();
    @(negedge clk); @(negedge clk); #2 rst_n = 1'b1;
  endtask

  task automatic wait_pulse(input string name, input int maxc, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!tv && n < maxc);
    checks++;
    if (!tv) begin
      errors++;
      $display("FAIL %s: tvalid 0 after %0d cycles, required a pulse", name, maxc);
    end
  endtask

  task automatic count_pulses(input int ncyc, output int cnt);
    cnt = 0;
    repeat (ncyc) begin @(negedge clk); if (tv) cnt++; end
  endtask

  initial begin
    int n, cnt;
    int seq[4];
    int gap[4];
    clear_inputs();
    model_reset();

    // Reset state
    @(negedge clk); #1;
    check("rst_tvalid", 32'(tv), 0);
    check("rst_tdata", td, 0);
    check("rst_tuser", 32'(tu), 0);
    check("rst_active", 32'(act), 0);
    check("rst_tready", 32'(s_tready), 0);
    #1 rst_n = 1'b1;

    // Single load, first-frame latency
    @(negedge clk); set_src(2, 32'h12345678, 8'h01);
    @(negedge clk); clear_inputs(); check("t1_no_early", 32'(tv), 0);
    @(negedge clk);
    check("t1_tvalid", 32'(tv), 1);
    check("t1_tdata", td, 32'h12345678);
    check("t1_tuser", 32'(tu), 32'h01);
    check("t1_active", 32'(act), 2);
    check("t1_model_tdata", e_td, 32'h12345678);

    // Rotation order and spacing, then hold
    do_reset();
    @(negedge clk);
    set_src(0, 32'hA0A0A0A0, 8'h0A); set_src(1, 32'hA1A1A1A1, 8'h1A); set_src(3, 32'hA3A3A3A3, 8'h3A);
    @(negedge clk); clear_inputs();
    wait_pulse("t2_p0", 5, n); seq[0] = act; gap[0] = n;
    for (int p = 1; p < 4; p++) begin
      wait_pulse("t2_pn", 20, n); seq[p] = act; gap[p] = n;
    end
    check("t2_first_lat", 32'(gap[0]), 1);
    check("t2_seq0", 32'(seq[0]), 0);
    check("t2_seq1", 32'(seq[1]), 1);
    check("t2_seq2", 32'(seq[2]), 3);
    check("t2_seq3", 32'(seq[3]), 0);
    check("t2_gap1", 32'(gap[1]), 9);
    check("t2_gap2", 32'(gap[2]), 9);
    check("t2_gap3", 32'(gap[3]), 9);
    wait_pulse("t2_p4", 20, n);
    check("t2_p4_active", 32'(act), 1);
    hold = 1'b1;
    count_pulses(30, cnt);
    check("t2_hold_pulses", 32'(cnt), 0);
    check("t2_hold_active", 32'(act), 1);
    hold = 1'b0;
    wait_pulse("t2_release", 20, n);
    check("t2_release_active", 32'(act), 3);

    // Live update of the active source
    do_reset();
    @(negedge clk);
    set_src(0, 32'hB0B0B0B0, 8'h0B); set_src(1, 32'hB1B1B1B1, 8'h1B); set_src(3, 32'hB3B3B3B3, 8'h3B);
    @(negedge clk); clear_inputs();
    wait_pulse("t3_p0", 5, n);
    wait_pulse("t3_p1", 20, n);
    check("t3_p1_active", 32'(act), 1);
    @(negedge clk); @(negedge clk);
    set_src(1, 32'hDEADBEEF, 8'hA5);
    @(negedge clk); clear_inputs(); check("t3_no_early", 32'(tv), 0);
    @(negedge clk);
    check("t3_live_tvalid", 32'(tv), 1);
    check("t3_live_tdata", td, 32'hDEADBEEF);
    check("t3_live_tuser", 32'(tu), 32'hA5);
    check("t3_live_active", 32'(act), 1);
    wait_pulse("t3_rot", 20, n);
    check("t3_rot_gap", 32'(n), 5);
    check("t3_rot_active", 32'(act), 3);

    // Clear active source, then clear the last one
    do_reset();
    @(negedge clk); set_src(0, 32'h0000AAAA, 8'h01); set_src(3, 32'h33333333, 8'h80);
    @(negedge clk); clear_inputs();
    wait_pulse("t4_p0", 5, n);
    check("t4_p0_active", 32'(act), 0);
    @(negedge clk); @(negedge clk);
    src_clear = 4'b0001;
    @(negedge clk); clear_inputs(); check("t4_gap1", 32'(tv), 0);
    @(negedge clk); check("t4_gap2", 32'(tv), 0);
    @(negedge clk);
    check("t4_tvalid", 32'(tv), 1);
    check("t4_active", 32'(act), 3);
    check("t4_tdata", td, 32'h33333333);
    src_clear = 4'b1000;
    @(negedge clk); clear_inputs();
    count_pulses(30, cnt);
    check("t4_idle_pulses", 32'(cnt), 0);
    check("t4_frozen_tdata", td, 32'h33333333);
    check("t4_frozen_tuser", 32'(tu), 32'h80);

    // Write+clear same slot; dwell expiry with active-slot write
    do_reset();
    @(negedge clk);
    set_src(1, 32'h11111111, 8'h11); set_src(2, 32'h22222222, 8'h22); src_clear = 4'b0010;
    @(negedge clk); clear_inputs();
    @(negedge clk);
    check("t5_wc_tvalid", 32'(tv), 1);
    check("t5_wc_active", 32'(act), 1);
    check("t5_wc_tdata", td, 32'h11111111);
    repeat (7) @(negedge clk);
    set_src(1, 32'hCAFEF00D, 8'hCF);
    @(negedge clk); clear_inputs(); check("t5_exp_gap", 32'(tv), 0);
    @(negedge clk);
    check("t5_rot_tvalid", 32'(tv), 1);
    check("t5_rot_active", 32'(act), 2);
    check("t5_rot_tdata", td, 32'h22222222);
    wait_pulse("t5_turn", 20, n);
    check("t5_turn_gap", 32'(n), 9);
    check("t5_turn_active", 32'(act), 1);
    check("t5_turn_tdata", td, 32'hCAFEF00D);

    // Asynchronous reset mid-SHOW
    do_reset();
    @(negedge clk); set_src(0, 32'h0F0F0F0F, 8'hFF);
    @(negedge clk); clear_inputs();
    wait_pulse("t6_p0", 5, n);
    check("t6_pre_tdata", td, 32'h0F0F0F0F);
    @(negedge clk); #3 rst_n = 1'b0; #1;
    check("t6_rst_tvalid", 32'(tv), 0);
    check("t6_rst_tdata", td, 0);
    check("t6_rst_tuser", 32'(tu), 0);
    check("t6_rst_active", 32'(act), 0);
    check("t6_rst_tready", 32'(s_tready), 0);
    repeat (3) @(negedge clk);
    #4 rst_n = 1'b1;
    count_pulses(30, cnt);
    check("t6_post_pulses", 32'(cnt), 0);
    check("t6_post_tdata", td, 0);

    // Randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < NS; i++) begin
        s_tvalid[i] = ($urandom_range(0, 15) == 0);
        src_clear[i] = ($urandom_range(0, 19) == 0);
      end
      s_tdata = {$urandom, $urandom, $urandom, $urandom};
      s_tuser = $urandom;
      if ($urandom_range(0, 29) == 0) hold = ~hold;
      if ($urandom_range(0, 999) == 0) begin
        #2 rst_n = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        #3 rst_n = 1'b1;
      end
    end
    clear_inputs();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_segment_scheduler.md
SEVEN_SEGMENT_SCHEDULER -- requirements
Module: seven_segment_scheduler

Interface
REQ-001 SHALL have parameter NUM_SEGMENTS, default 8: digits per display frame.
REQ-002 SHALL have parameter NUM_SRC, default 4, legal range 2..16: number of requesters sharing the display.
REQ-003 SHALL have parameter DWELL_CYCLES, default 50000000, minimum 2: clk cycles each source is shown before rotation.
REQ-004 SHALL have port clk  input  1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1: one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port s_tvalid  input  NUM_SRC: per-source frame valid.
REQ-007 SHALL have port s_tready  output  NUM_SRC: per-source ready.
REQ-008 SHALL have port s_tdata  input  NUM_SRC*NUM_SEGMENTS*4: source i frame at bits [i*NUM_SEGMENTS*4 +: NUM_SEGMENTS*4], 4 bits per digit.
REQ-009 SHALL have port s_tuser  input  NUM_SRC*NUM_SEGMENTS: source i digit points at [i*NUM_SEGMENTS +: NUM_SEGMENTS], 1 = point lit.
REQ-010 SHALL have port src_clear  input  NUM_SRC: per-source request to drop its slot.
REQ-011 SHALL have port hold  input  1: 1 = freeze rotation on current source.
REQ-012 SHALL have port seven_segment_tvalid  output  1: single-cycle frame-update strobe to the display driver.
REQ-013 SHALL have port seven_segment_tdata  output  NUM_SEGMENTS*4: frame digits.
REQ-014 SHALL have port seven_segment_tuser  output  NUM_SEGMENTS: frame digit points.
REQ-015 SHALL have port active_src  output  $clog2(NUM_SRC): index of source currently displayed.

Function
REQ-016 SHALL hold one slot per source: data, user, loaded flag.
REQ-017 SHALL drive s_tready[i]=1 whenever rst_n=1; handshake on edge k writes slot i and sets loaded[i] at edge k (overwrite, no buffering beyond one frame).
REQ-018 SHALL clear loaded[i] when src_clear[i]=1 and s_tvalid[i]=0; simultaneous write and clear on same slot: write wins, loaded stays 1.
REQ-019 SHALL implement FSM states IDLE, SHOW, NEXT.
REQ-020 IDLE: when any loaded=1, SHALL select lowest-index loaded slot, copy its data/user to outputs, set active_src, pulse seven_segment_tvalid, clear dwell counter, go SHOW.
REQ-021 SHOW: dwell counter SHALL count 0..DWELL_CYCLES-1; at count DWELL_CYCLES-1 with hold=0 go NEXT; with hold=1 wrap counter to 0 and stay SHOW.
REQ-022 SHOW: if slot active_src is written on edge k, outputs SHALL copy the new frame and pulse seven_segment_tvalid for the cycle after edge k+1 (live update).
REQ-023 SHOW: if loaded[active_src] becomes 0, SHALL go NEXT on the following edge regardless of counter or hold.
REQ-024 NEXT (one cycle): SHALL search loaded slots round-robin starting at active_src+1 modulo NUM_SRC, wrapping through active_src itself; first hit is copied to outputs, active_src updated, tvalid pulsed, counter cleared, go SHOW; no hit -> IDLE, no pulse.
REQ-025 Dwell expiry and write to active slot in same cycle: rotation SHALL win; new data remains in slot for its next turn.
REQ-026 Latency: handshake on edge k into empty scheduler SHALL produce tvalid during the cycle after edge k+1.
REQ-027 Steady rotation SHALL give tvalid pulses exactly DWELL_CYCLES+1 cycles apart (single loaded source included).
REQ-028 seven_segment_tvalid SHALL never be high for two consecutive cycles except back-to-back live updates; tdata/tuser SHALL only change with a tvalid pulse.
REQ-029 After all slots cleared, outputs SHALL hold last frame, tvalid stays 0.

Reset
REQ-030 rst_n=0 SHALL asynchronously force: state IDLE, all loaded=0, counter 0, active_src 0, s_tready all 0, seven_segment_tvalid 0, tdata all 0, tuser all 0.
REQ-031 Reset asserted mid-SHOW or mid-NEXT SHALL discard all slots; no tvalid pulse on or after release until a new handshake.

Verification (NUM_SRC=4, NUM_SEGMENTS=8, DWELL_CYCLES=8)
REQ-032 Load src 2 with 0x12345678, tuser 0x01 on edge k -> tvalid cycle after edge k+1, tdata 0x12345678, tuser 0x01, active_src 2.
REQ-033 Sources 0,1,3 loaded -> active_src sequence 0,1,3,0 with tvalid every 9 cycles; asserting hold during src 1 -> stays 1, no pulses until released.
REQ-034 Rewrite active src 1 with 0xDEADBEEF mid-dwell -> pulse 2 cycles later with new data, active_src unchanged, rotation timing unaffected.
REQ-035 src_clear active src 0 with src 3 loaded -> NEXT then src 3 shown; clear src 3 -> IDLE, outputs frozen, tvalid 0.
REQ-036 Write and clear same slot same cycle -> slot loaded; dwell expiry coinciding with active-slot write -> rotates, new data shown on next turn.
REQ-037 rst_n low for 3 cycles mid-SHOW, asynchronous to clk -> all outputs zero immediately, no tvalid after release until new handshake.
